multi_edge_detect: RTL
======================

MULTI_EDGE_DETECT -- requirements
Module: multi_edge_detect

Interface
REQ-001 SHALL have parameter NCH, default 8, number of independent input channels (1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, flip-flop synchroniser depth per channel (1..4).
REQ-003 SHALL have parameter DEB_W, default 8, width of the debounce length and counters.
REQ-004 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  synchronous reset, active-high.
REQ-006 sign_i  input  NCH  raw, possibly asynchronous, channel inputs.
REQ-007 mode_i  input  2*NCH  per-channel mode, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both.
REQ-008 deb_len_i  input  DEB_W  debounce length D, shared by all channels, in clk_i cycles.
REQ-009 clr_i  input  NCH  per-channel pending-clear pulse.
REQ-010 ien_i  input  NCH  per-channel interrupt enable.
REQ-011 level_o  output  NCH  debounced level per channel.
REQ-012 edge_o  output  NCH  one-cycle pulse per qualifying edge.
REQ-013 pend_o  output  NCH  sticky pending flags.
REQ-014 irq_o  output  1  OR of (pend_o AND ien_i).

Function
REQ-015 Each channel SHALL pass sign_i through SYNC_STAGES registers; sync output = last stage.
REQ-016 Each channel SHALL hold a filtered level filt and a DEB_W-bit counter cnt.
REQ-017 On each edge: sync == filt -> cnt SHALL clear to 0, filt unchanged.
REQ-018 On each edge: sync != filt and cnt >= D -> filt SHALL take sync, cnt SHALL clear to 0.
REQ-019 On each edge: sync != filt and cnt < D -> cnt SHALL increment by 1; cnt never wraps.
REQ-020 D = 0 SHALL bypass filtering: filt follows sync one edge later.
REQ-021 A sync-output pulse shorter than D+1 cycles SHALL NOT change filt.
REQ-022 Lowering deb_len_i below an in-progress cnt SHALL cause filt to update on the next edge (>= compare).
REQ-023 A registered copy filt_d SHALL track filt one edge behind.
REQ-024 rise = filt AND NOT filt_d; fall = filt_d AND NOT filt; edge_o[i] SHALL be combinational from rise/fall gated by mode_i[i].
REQ-025 A mode_i change SHALL affect edge_o in the same cycle; mode 00 SHALL suppress edge_o and pending set.
REQ-026 Latency: a change of sign_i sampled at edge 0 and held stable SHALL assert edge_o for exactly one cycle following edge SYNC_STAGES+D+... i.e. filt changes at edge SYNC_STAGES+D, edge_o high until the next edge.
REQ-027 level_o SHALL equal filt.
REQ-028 pend_o[i] SHALL set on the edge where edge_o[i] is high, clear on an edge where clr_i[i] is high; set SHALL win over simultaneous clear.
REQ-029 irq_o SHALL be combinational from pend_o and ien_i; toggling ien_i SHALL NOT alter pend_o.
REQ-030 Channels SHALL be fully independent; simultaneous edges on any set of channels SHALL all be reported in the same cycle.

Reset
REQ-031 rst_i high at an edge SHALL clear sync registers, filt, filt_d, cnt, pend to 0; thus edge_o=0, level_o=0, pend_o=0, irq_o=0 in the following cycle.
REQ-032 Reset mid-debounce SHALL discard the count; a channel held high through reset SHALL report a rising edge after SYNC_STAGES+D edges post-release (if mode enables rising).
REQ-033 Reset SHALL take precedence over clr_i and edge-set.

Verification
REQ-034 SYNC_STAGES=2, D=0, mode=10, ch0 1->0 -> edge_o[0] one-cycle pulse, filt change at edge 2, pend_o[0]=1 after.
REQ-035 D=3, mode=11, ch1 glitch 3 cycles high -> no edge_o; 4-cycle high -> rising pulse then falling pulse on release.
REQ-036 pend_o[2]=1, clr_i[2] and new edge same cycle -> pend_o[2] stays 1; clr_i alone next -> 0; irq_o follows with ien_i[2]=1, stays 0 with ien_i[2]=0.
REQ-037 All NCH channels toggle 0->1 together, mode=01 -> edge_o all-ones for one cycle, pend_o all-ones.
REQ-038 rst_i pulse with cnt=2 of D=5 -> cnt, pend_o, level_o 0; sign_i held 1 -> rising edge after SYNC_STAGES+5 edges.

Source files
------------

// File: rtl/multi_edge_detect.sv
// Purpose : per-channel synchroniser, debounce filter and edge detector with sticky pending flags and an interrupt.
// Latency : an input change sampled at edge 0 moves level_o at edge SYNC_STAGES+D; edge_o pulses for the following cycle.
// Backpressure: none; every channel updates every cycle and edges are never dropped or queued.
//
// Ports:
//   clk_i      - single clock, all state on its rising edge
//   rst_i      - synchronous active-high reset
//   sign_i     - raw (possibly asynchronous) channel inputs
//   mode_i     - per-channel mode, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both
//   deb_len_i  - shared debounce length D in clk_i cycles
//   clr_i      - per-channel pending-clear pulse
//   ien_i      - per-channel interrupt enable
//   level_o    - debounced level per channel
//   edge_o     - one-cycle pulse per qualifying edge (combinational from filtered state and mode)
//   pend_o     - sticky pending flags
//   irq_o      - OR of (pend_o AND ien_i)
module multi_edge_detect #(
    parameter int NCH         = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_W       = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NCH-1:0]       sign_i,
    input  logic [2*NCH-1:0]     mode_i,
    input  logic [DEB_W-1:0]     deb_len_i,
    input  logic [NCH-1:0]       clr_i,
    input  logic [NCH-1:0]       ien_i,
    output logic [NCH-1:0]       level_o,
    output logic [NCH-1:0]       edge_o,
    output logic [NCH-1:0]       pend_o,
    output logic                 irq_o
);

    // Synchroniser chain, stage 0 samples the raw input.
    logic [NCH-1:0]   r_sync [SYNC_STAGES];
    logic [NCH-1:0]   r_filt;
    logic [NCH-1:0]   r_filt_d;
    logic [DEB_W-1:0] r_cnt  [NCH];
    logic [NCH-1:0]   r_pend;

    logic [NCH-1:0]   w_sync;
    logic [NCH-1:0]   w_rise;
    logic [NCH-1:0]   w_fall;
    logic [NCH-1:0]   w_en_rise;
    logic [NCH-1:0]   w_en_fall;
    logic [NCH-1:0]   w_edge;

    assign w_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
        end else begin
            r_sync[0] <= sign_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    // Debounce: the synchronised value must disagree with filt for D+1
    // consecutive edges before filt follows. The >= compare lets a lowered
    // deb_len_i take effect on the very next edge, and also stops cnt at D
    // so it can never wrap.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_filt   <= '0;
            r_filt_d <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_filt_d <= r_filt;
            for (int i = 0; i < NCH; i++) begin
                if (w_sync[i] == r_filt[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] >= deb_len_i) begin
                    r_filt[i] <= w_sync[i];
                    r_cnt[i]  <= '0;
                end else begin
                    r_cnt[i]  <= r_cnt[i] + DEB_W'(1);
                end
            end
        end
    end

    always_comb begin
        w_en_rise = '0;
        w_en_fall = '0;
        for (int i = 0; i < NCH; i++) begin
            w_en_rise[i] = mode_i[2*i];
            w_en_fall[i] = mode_i[2*i+1];
        end
    end

    assign w_rise = r_filt & ~r_filt_d;
    assign w_fall = r_filt_d & ~r_filt;
    assign w_edge = (w_rise & w_en_rise) | (w_fall & w_en_fall);

    // Pending: a new edge beats a simultaneous clear so no event is lost.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~clr_i) | w_edge;
        end
    end

    assign level_o = r_filt;
    assign edge_o  = w_edge;
    assign pend_o  = r_pend;
    assign irq_o   = |(r_pend & ien_i);

endmodule
